// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared constants and types for wave_capture / wave_display
// Purpose: sample RAM geometry, window width, display FSM states and the
//          per-stage pipeline record used by wave_display.
// Ports: none (package).
package wave_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int RAM_ADDR_W = 9;
    localparam int WIN_W      = 512;

    typedef enum logic {
        IDLE,
        DRAWING
    } state_e;

    // Per-pixel information carried alongside the RAM read.
    typedef struct packed {
        logic                in_window;
        logic [SAMPLE_W-1:0] y_half;     // y[8:1], one sample level per 2 rows
        logic                addr_chg;   // sample address moved on this pixel
        logic                line_start; // first column of the window
    } stage_t;

endpackage

// File: rtl/wave_display_if.sv
// rtl/wave_display_if.sv - sample RAM read port between wave_display and the RAM/capture side
// Purpose: groups the buffer select, read address and read data of the shared
//          512x8 sample RAM.
// Signals: read_index   - buffer half most recently completed by wave_capture
//          read_address - {frame_index, sample[7:0]}
//          read_value   - synchronous read data, valid 1 cycle after read_address
// Modports: master (wave_display), slave (RAM / wave_capture side).
interface wave_display_if;
    import wave_pkg::*;

    logic                  read_index;
    logic [RAM_ADDR_W-1:0] read_address;
    logic [SAMPLE_W-1:0]   read_value;

    modport master (
        input  read_index,
        input  read_value,
        output read_address
    );

    modport slave (
        output read_index,
        output read_value,
        input  read_address
    );

endinterface

// File: rtl/wave_pixel_cmp.sv
// rtl/wave_pixel_cmp.sv - stage-2 segment compare with previous-sample register
// Purpose: lights a pixel when the row's target level lies between the previous
//          and current sample, giving continuous vertical segments at steps.
// Ports: clk, reset          - clock, synchronous active-high reset
//        cur_sample_i        - sample returned by the RAM for this pixel
//        target_i            - sample level represented by this row
//        in_window_i         - pixel lies inside the waveform window
//        addr_changed_i      - sample address differs from the previous pixel
//        line_start_i        - first column of the window
//        lit_o               - waveform pixel lit (combinational)
module wave_pixel_cmp
    import wave_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] cur_sample_i,
    input  logic [SAMPLE_W-1:0] target_i,
    input  logic                in_window_i,
    input  logic                addr_changed_i,
    input  logic                line_start_i,
    output logic                lit_o
);

    logic [SAMPLE_W-1:0] prev_sample_q;
    logic [SAMPLE_W-1:0] prev_eff;
    logic [SAMPLE_W-1:0] lo;
    logic [SAMPLE_W-1:0] hi;

    // The last sample of the previous line must not join the first of this one.
    assign prev_eff = line_start_i ? cur_sample_i : prev_sample_q;
    assign lo       = (prev_eff < cur_sample_i) ? prev_eff : cur_sample_i;
    assign hi       = (prev_eff < cur_sample_i) ? cur_sample_i : prev_eff;
    assign lit_o    = in_window_i && (lo <= target_i) && (target_i <= hi);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_sample_q <= 8'h80;
        end else if (addr_changed_i || line_start_i) begin
            prev_sample_q <= cur_sample_i;
        end
    end

endmodule

// File: rtl/wave_display.sv
// rtl/wave_display.sv - draws the captured waveform on the VGA raster
// Purpose: reads samples from the half of the sample RAM chosen at frame start,
//          and produces per-pixel colour with 2-cycle latency from x/y/valid.
//          Optional grid overlay: define WAVE_DISPLAY_GRID_EN.
// Ports: clk, reset         - clock, synchronous active-high reset
//        x, y, valid        - current VGA column/row, active-video flag
//        ram                - sample RAM read port (wave_display_if.master)
//        valid_pixel, r,g,b - pixel driven by this block and its colour
//        wave_display_idle  - high when not drawing the window (buffer flip allowed)
module wave_display
    import wave_pkg::*;
#(
    parameter int          X_START    = 256,
    parameter int          Y_HEIGHT   = 512,
    parameter logic [23:0] WAVE_COLOR = 24'hFFFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x,
    input  logic [9:0]    y,
    input  logic          valid,
    wave_display_if.master ram,
    output logic          valid_pixel,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b,
    output logic          wave_display_idle
);

    localparam logic [10:0] X_LO   = 11'(X_START);
    localparam logic [10:0] X_LAST = 11'(X_START + WIN_W - 1);
    localparam logic [9:0]  Y_LAST = 10'(Y_HEIGHT - 1);
    localparam logic [9:0]  Y_END  = 10'(Y_HEIGHT);

    state_e                state_q, state_d;
    logic                  frame_index_q, frame_index_d;
    logic [RAM_ADDR_W-1:0] read_address_q, read_address_d;
    logic                  idle_q;
    stage_t                s0_q, s0_d, s1_q;
    logic                  valid_pixel_q, valid_pixel_d;
    logic [23:0]           rgb_q, rgb_d;

    logic [10:0]           col;
    logic                  in_window;
    logic                  frame_start;
    logic                  frame_end;
    logic [SAMPLE_W-1:0]   target;
    logic                  lit;

    assign col         = x - X_LO;
    assign in_window   = valid && (y < Y_END) && (x >= X_LO) && (x <= X_LAST);
    assign frame_start = valid && (y == '0) && (x == X_LO);
    assign frame_end   = (valid && (y == Y_LAST) && (x == X_LAST)) || (y >= Y_END);

    always_comb begin
        state_d       = state_q;
        frame_index_d = frame_index_q;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d       = DRAWING;
                    frame_index_d = ram.read_index;
                end
            end
            DRAWING: begin
                if (frame_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // frame_index_d already carries read_index on the frame-start pixel.
    always_comb begin
        s0_d            = '0;
        read_address_d  = {frame_index_d, col[8:1]};
        s0_d.in_window  = in_window;
        s0_d.y_half     = y[8:1];
        s0_d.addr_chg   = (read_address_d != read_address_q);
        s0_d.line_start = (col == '0);
    end

    assign target = 8'hFF - s1_q.y_half;

    wave_pixel_cmp u_cmp (
        .clk            (clk),
        .reset          (reset),
        .cur_sample_i   (ram.read_value),
        .target_i       (target),
        .in_window_i    (s1_q.in_window),
        .addr_changed_i (s1_q.addr_chg),
        .line_start_i   (s1_q.line_start),
        .lit_o          (lit)
    );

`ifdef WAVE_DISPLAY_GRID_EN
    logic grid_s0_q, grid_s1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            grid_s0_q <= 1'b0;
            grid_s1_q <= 1'b0;
        end else begin
            grid_s0_q <= (col[5:0] == '0) || (y[5:0] == '0);
            grid_s1_q <= grid_s0_q;
        end
    end
`endif

    always_comb begin
        valid_pixel_d = 1'b0;
        rgb_d         = '0;
        if (lit) begin
            valid_pixel_d = 1'b1;
            rgb_d         = WAVE_COLOR;
        end
`ifdef WAVE_DISPLAY_GRID_EN
        else if (s1_q.in_window && grid_s1_q) begin
            valid_pixel_d = 1'b1;
            rgb_d         = 24'h404040;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            frame_index_q  <= 1'b0;
            read_address_q <= '0;
            idle_q         <= 1'b1;
            s0_q           <= '0;
            s1_q           <= '0;
            valid_pixel_q  <= 1'b0;
            rgb_q          <= '0;
        end else begin
            state_q        <= state_d;
            frame_index_q  <= frame_index_d;
            read_address_q <= read_address_d;
            idle_q         <= (state_d == IDLE);
            s0_q           <= s0_d;
            s1_q           <= s0_q;
            valid_pixel_q  <= valid_pixel_d;
            rgb_q          <= rgb_d;
        end
    end

    assign ram.read_address  = read_address_q;
    assign valid_pixel       = valid_pixel_q;
    assign {r, g, b}         = rgb_q;
    assign wave_display_idle = idle_q;

endmodule

// File: tb/tb_wave_display.sv
// tb/tb_wave_display.sv - directed self-checking bench for wave_display
module tb_wave_display;
    import wave_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        valid_pixel;
    logic [7:0]  r, g, b;
    logic        wave_display_idle;

    wave_display_if rif ();

    logic [7:0] mem [0:511];

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    e1, e2, c1, c2;
    string t1, t2;

    always #5 clk = ~clk;

    always @(posedge clk) rif.read_value <= mem[rif.read_address];

    wave_display dut (
        .clk               (clk),
        .reset             (reset),
        .x                 (x),
        .y                 (y),
        .valid             (valid),
        .ram               (rif.master),
        .valid_pixel       (valid_pixel),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .wave_display_idle (wave_display_idle)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int xx, input int yy, input bit vv);
        x     = 11'(xx);
        y     = 10'(yy);
        valid = vv;
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel; the output now visible belongs to the pixel two ticks back.
    task automatic px(input int xx, input int yy, input bit vv, input bit ce, input bit ev);
        tick(xx, yy, vv);
        if (c2) begin
            check(t2, valid_pixel, e2);
            check({t2, " rgb"}, {r, g, b}, e2 ? 24'hFFFFFF : 24'h000000);
        end
        e2 = e1; c2 = c1; t2 = t1;
        e1 = ev; c1 = ce; t1 = $sformatf("pix x=%0d y=%0d", xx, yy);
    endtask

    // Flat waveform at level v: only the row pair of that level is lit.
    function automatic bit flat_lit(input int xx, input int yy, input int v);
        int col = xx - 256;
        return (col >= 0) && (col < 512) && ((255 - ((yy >> 1) & 255)) == v);
    endfunction

    // Samples 0..5 = 0x10, 6.. = 0xF0: the step column 12 carries the full segment.
    function automatic bit step_lit(input int xx, input int yy);
        int col = xx - 256;
        int t   = 255 - ((yy >> 1) & 255);
        if (col < 0 || col >= 512) return 1'b0;
        if (col == 12) return (t >= 16) && (t <= 240);
        return t == (((col >> 1) < 6) ? 16 : 240);
    endfunction

    initial begin
        int rows [8] = '{28, 30, 31, 100, 200, 478, 479, 480};

        for (int i = 0; i < 512; i++) mem[i] = (i < 256) ? 8'h00 : 8'h80;
        rif.read_index = 1'b0;
        c1 = 1'b0; c2 = 1'b0; e1 = 1'b0; e2 = 1'b0;

        // Reset held 4 cycles
        reset = 1'b1;
        repeat (4) tick(0, 0, 0);
        check("reset idle", wave_display_idle, 1);
        check("reset valid_pixel", valid_pixel, 0);
        check("reset read_address", rif.read_address, 0);
        check("reset rgb", {r, g, b}, 0);
        reset = 1'b0;

        // Rows below the window: nothing drawn, stays idle
        for (int xx = 240; xx < 800; xx += 4) begin
            px(xx, 600, 1, 1, 0);
            check("idle y600", wave_display_idle, 1);
        end

        // Frame start latches read_index; mid-frame toggles are ignored
        rif.read_index = 1'b1;
        px(256, 0, 1, 1, 0);
        check("start addr", rif.read_address, 9'h100);
        check("start idle", wave_display_idle, 0);
        px(257, 0, 1, 1, 0);
        check("addr x257", rif.read_address, 9'h100);
        px(258, 0, 1, 1, 0);
        check("addr x258", rif.read_address, 9'h101);
        rif.read_index = 1'b0;
        px(260, 0, 1, 1, 0);
        check("addr x260 idx held", rif.read_address, 9'h102);
        px(262, 0, 1, 1, 0);
        check("addr x262 idx held", rif.read_address, 9'h103);

        // Flat 0x80 in half 1 (half 0 is zero, so the wrong half would show)
        for (int yy = 254; yy <= 256; yy++)
            for (int xx = 252; xx < 772; xx++)
                px(xx, yy, 1, 1, flat_lit(xx, yy, 128));
        px(300, 254, 0, 1, 0);
        check("blank keeps drawing", wave_display_idle, 0);

        // Step 0x10 -> 0xF0 between samples 5 and 6
        for (int i = 256; i < 512; i++) mem[i] = ((i - 256) < 6) ? 8'h10 : 8'hF0;
        for (int k = 0; k < 8; k++)
            for (int xx = 252; xx < 772; xx++)
                px(xx, rows[k], 1, 1, step_lit(xx, rows[k]));

        // Frame end, next frame, reset mid-frame
        for (int i = 256; i < 512; i++) mem[i] = 8'hCD;
        rif.read_index = 1'b1;
        px(766, 511, 1, 1, 0);
        check("before end idle", wave_display_idle, 0);
        px(767, 511, 1, 1, 0);
        check("frame end idle", wave_display_idle, 1);
        px(256, 0, 1, 1, 0);
        check("frame2 idle", wave_display_idle, 0);
        check("frame2 addr", rif.read_address, 9'h100);
        px(300, 100, 1, 1, 1);
        px(301, 100, 1, 1, 1);
        px(302, 100, 1, 1, 1);
        reset = 1'b1;
        c1 = 1'b0; c2 = 1'b0;
        tick(303, 100, 1);
        check("midreset valid_pixel", valid_pixel, 0);
        check("midreset rgb", {r, g, b}, 0);
        check("midreset idle", wave_display_idle, 1);
        check("midreset read_address", rif.read_address, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(304 + 2 * i, 100, 1);
            check("post reset idle", wave_display_idle, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_display.md
Name: wave_display

Overview:
- Read-side counterpart of wave_capture; draws the captured waveform on the VGA raster.
- Reads 8-bit samples from the shared 512x8 dual-port sample RAM, using the half selected by wave_capture's read_index.
- Produces per-pixel colour for the VGA pipeline.
- Asserts wave_display_idle outside the waveform window so wave_capture may flip buffers.

Parameters:
- X_START, 256: first pixel column of the waveform window; window is 512 columns wide, each sample spans 2 columns.
- Y_HEIGHT, 512: window rows 0..Y_HEIGHT-1; sample value v maps to row 2*(255-v).
- WAVE_COLOR, 24'hFFFFFF: {r,g,b} of a lit waveform pixel.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- x  in  11  current VGA column
- y  in  10  current VGA row
- valid  in  1  x/y inside the active video area
- read_index  in  1  buffer half most recently completed by wave_capture
- read_address  out  9  sample RAM read address {frame_index, sample[7:0]}
- read_value  in  8  RAM data; synchronous read, valid 1 cycle after read_address
- valid_pixel  out  1  this block drives a lit pixel (2-cycle latency from x/y)
- r  out  8  red component
- g  out  8  green component
- b  out  8  blue component
- wave_display_idle  out  1  high when not drawing the window

Behaviour:
- Reset: read_address=0, valid_pixel=0, r=g=b=0, wave_display_idle=1, state=IDLE, frame_index=0, prev_sample=8'h80.
- FSM states: IDLE, DRAWING.
  - IDLE->DRAWING: valid && y==0 && x==X_START. On this edge latch frame_index<=read_index; frame_index then holds for the whole frame.
  - DRAWING->IDLE: valid && y==Y_HEIGHT-1 && x==X_START+511, or y>=Y_HEIGHT seen.
  - wave_display_idle = (state==IDLE), registered.
- Stage 0, address:
  - in_window = valid && y<Y_HEIGHT && X_START<=x<X_START+512.
  - read_address <= {frame_index, (x-X_START)[8:1]}, registered.
  - On the IDLE->DRAWING edge, use read_index directly for this address.
  - Subtraction is 11-bit; only bits [8:1] are used.
- Stage 1, data: read_value is returned. Stage-0 in_window, y and the address-change flag are delayed to align with it.
- Stage 2, compare:
  - When the sample address differs from the previous cycle's, prev_sample <= current sample.
  - At column X_START (start of each line), prev_sample <= current sample, so there is no false segment from the previous line.
  - target = 255 - y[8:1]. Pixel is lit if in_window_d && min(prev,cur) <= target <= max(prev,cur). This gives a continuous vertical segment at steps.
  - Lit: valid_pixel=1, {r,g,b}=WAVE_COLOR. Otherwise valid_pixel=0 and r=g=b=0.
- Latency: exactly 2 clk from x/y/valid to valid_pixel/r/g/b; the VGA top delays sync by 2.
- read_index toggling while DRAWING has no effect until the next frame.
- Reset mid-frame: outputs clear next cycle; the block returns to IDLE and waits for the next frame start.
- valid low inside the window region (blanking): pixel 0, state unchanged.

Optional Feature:
- Macro WAVE_DISPLAY_GRID_EN.
- Defined: inside the window, unlit pixels with (x-X_START)[5:0]==0 or y[5:0]==0 output valid_pixel=1, {r,g,b}=24'h404040. The waveform has priority over the grid.
- Undefined: no grid; unlit window pixels are valid_pixel=0.

Decomposition:
- Shared package wave_pkg: SAMPLE_W=8, RAM_ADDR_W=9, WIN_W=512, state enum {IDLE, DRAWING}.
- wave_capture uses the same constants.
- Natural sub-module: wave_pixel_cmp, the stage-2 min/max/target compare with the prev_sample register.

Test Plan:
- Reset held 4 cycles -> wave_display_idle=1, valid_pixel=0, read_address=0; after release, y=600 sweep -> still idle, no pixels.
- read_index=1, frame start at x=256,y=0 -> read_address=9'h100; x=258 -> 9'h101; read_index toggled to 0 mid-frame -> address MSB stays 1 until the next frame.
- RAM all 8'h80, y=254 (target 128) -> valid_pixel=1 at every window column, 2 cycles after input; y=256 -> valid_pixel=0.
- Samples step 8'h10->8'hF0 at addr 5/6 -> every row between target 16..240 lit at column X_START+12; other columns lit only at their own row.
- Frame end at y=511, x=767 -> wave_display_idle rises within 1 cycle; reset asserted at y=100 -> outputs 0 next cycle, idle=1.
- With WAVE_DISPLAY_GRID_EN, flat 8'h80 -> pixel at x=320,y=64 gives 24'h404040, and the waveform row stays 24'hFFFFFF.
